serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/fs_bit.sv | 13 +
 rtl/serial_sub_ctrl.sv | 101 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fs_bit.sv
// Single full-subtractor bit slice: d = a - b - bi, bo is the borrow out.
module fs_bit (
  output logic bo,
  output logic d,
  input  logic a,
  input  logic b,
  input  logic bi
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fs_bit slice walks the operands LSB first, one bit per clock.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             slice_d;
  logic             slice_bo;

  fs_bit u_fs_bit (
    .bo (slice_bo),
    .d  (slice_d),
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .bi (br_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          d_d     = '0;
          bout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[cnt_q] = slice_d;
        br_d       = slice_bo;
        // Counter stops at the last bit rather than wrapping.
        if (cnt_q == LAST) begin
          bout_d  = slice_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8): directed corner cases plus randomized operands.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  logic [W:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 9-bit subtraction; bit 8 is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    a = x; b = y; bin = c; start = 1'b1;
    exp_q.push_back(ref_sub(x, y, c));
    @(negedge clk);
    acc_cyc = cyc;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 30) begin
      @(negedge clk);
      if (done) begin
        c = cyc;
        break;
      end
      n++;
    end
    if (c < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c1, c2, c3, dc;
    fork
      forever begin
        @(negedge clk);
        if (done === 1'b1) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("sb_d", 32'(d), 32'(e[W-1:0]));
            chk("sb_bout", 32'(bout), 32'(e[W]));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    // Basic results and latency
    issue(8'h05, 8'h03, 1'b0);
    wait_done(c1);
    chk("latency", 32'(c1 - acc_cyc), 32'd8);
    chk("d_05_03", 32'(d), 32'h02);
    issue(8'h03, 8'h05, 1'b0);
    wait_done(c1);
    chk("d_03_05", 32'(d), 32'hFE);
    chk("bout_03_05", 32'(bout), 32'd1);
    issue(8'h00, 8'h00, 1'b1);
    wait_done(c1);
    chk("d_00_00_bin", 32'(d), 32'hFF);
    repeat (3) @(negedge clk);
    chk("hold_d", 32'(d), 32'hFF);
    chk("hold_bout", 32'(bout), 32'd1);

    // Start held high during RUN is ignored
    dc = done_cnt;
    issue(8'hFF, 8'h00, 1'b0);
    start = 1'b1; a = 8'h11;
    wait_done(c1);
    start = 1'b0;
    chk("held_start_d", 32'(d), 32'hFF);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("single_done", 32'(done_cnt - dc), 32'd1);

    // Reset in the middle of RUN aborts
    dc = done_cnt;
    issue(8'h5A, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    issue(8'h80, 8'h01, 1'b0);
    wait_done(c1);
    chk("after_abort_d", 32'(d), 32'h7F);

    // Back-to-back throughput
    issue(8'h10, 8'h01, 1'b0);
    wait_done(c1);
    issue(8'h20, 8'h30, 1'b1);
    wait_done(c2);
    issue(8'hA5, 8'h5A, 1'b0);
    wait_done(c3);
    chk("spacing_1", 32'(c2 - c1), 32'd10);
    chk("spacing_2", 32'(c3 - c2), 32'd10);

    // Randomized operands
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(8'($urandom), 8'($urandom), 1'($urandom));
    end
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
